// File: rtl/siso_arbiter_ctrl_if.sv
// Requester-side bundle of the siso arbiter: two request/word pairs and their grant pulses.
interface siso_arbiter_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             gnt0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             gnt1;

  modport master (output req0, data0, req1, data1, input gnt0, gnt1);
  modport slave  (input req0, data0, req1, data1, output gnt0, gnt1);
endinterface

// File: rtl/siso_arbiter_ctrl.sv
// Round-robin arbiter that frames one granted word (start bit, MSB-first data, stop bit)
// onto the serial input of a shared siso shift register, with its shift-enable strobe.
module siso_arbiter_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  siso_arbiter_ctrl_if.slave  req_if,
  output logic                go_o,
  output logic                shift_en_o,
  output logic                frame_o,
  output logic                busy_o,
  output logic                owner_o
);

  // state   | meaning
  // S_IDLE  | waiting for a request, arbitration active
  // S_START | start bit (go=1), first cycle carries the grant pulse
  // S_SHIFT | WIDTH data bits, MSB first
  // S_STOP  | stop bit (go=0), then back to idle
  typedef enum logic [1:0] {S_IDLE, S_START, S_SHIFT, S_STOP} state_e;

  localparam int BW = $clog2(WIDTH);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  state_e           state_q, state_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [DW-1:0]    divcnt_q, divcnt_d;
  logic [WIDTH-1:0] shift_buf_q, shift_buf_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;

  logic div_last, bit_last, sel_valid, sel1;
  logic gnt0, gnt1;

  assign div_last  = (divcnt_q == DW'(DIV - 1));
  assign bit_last  = (bitcnt_q == BW'(WIDTH - 1));
  assign sel_valid = req_if.req0 | req_if.req1;
  // On a tie the requester that did not win last time is chosen.
  assign sel1      = req_if.req1 & (~req_if.req0 | ~last_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      divcnt_q    <= '0;
      shift_buf_q <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      divcnt_q    <= divcnt_d;
      shift_buf_q <= shift_buf_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    divcnt_d    = divcnt_q;
    shift_buf_d = shift_buf_q;
    owner_d     = owner_q;
    last_d      = last_q;
    go_o        = 1'b0;
    frame_o     = 1'b0;
    busy_o      = 1'b0;
    shift_en_o  = 1'b0;
    gnt0        = 1'b0;
    gnt1        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          state_d     = S_START;
          divcnt_d    = '0;
          bitcnt_d    = '0;
          shift_buf_d = sel1 ? req_if.data1 : req_if.data0;
          owner_d     = sel1;
          last_d      = sel1;
        end
      end
      S_START: begin
        go_o       = 1'b1;
        frame_o    = 1'b1;
        busy_o     = 1'b1;
        shift_en_o = div_last;
        gnt0       = (divcnt_q == '0) & ~owner_q;
        gnt1       = (divcnt_q == '0) & owner_q;
        if (div_last) begin
          state_d  = S_SHIFT;
          divcnt_d = '0;
          bitcnt_d = '0;
        end else begin
          divcnt_d = divcnt_q + DW'(1);
        end
      end
      S_SHIFT: begin
        // The buffer shifts left each bit period, so its MSB is always the current bit.
        go_o       = shift_buf_q[WIDTH-1];
        frame_o    = 1'b1;
        busy_o     = 1'b1;
        shift_en_o = div_last;
        if (div_last) begin
          divcnt_d    = '0;
          shift_buf_d = {shift_buf_q[WIDTH-2:0], 1'b0};
          if (bit_last) begin
            state_d  = S_STOP;
            bitcnt_d = '0;
          end else begin
            bitcnt_d = bitcnt_q + BW'(1);
          end
        end else begin
          divcnt_d = divcnt_q + DW'(1);
        end
      end
      S_STOP: begin
        busy_o     = 1'b1;
        shift_en_o = div_last;
        if (div_last) begin
          state_d  = S_IDLE;
          divcnt_d = '0;
        end else begin
          divcnt_d = divcnt_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_if.gnt0 = gnt0;
  assign req_if.gnt1 = gnt1;
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_siso_arbiter_ctrl.sv
// Bench for siso_arbiter_ctrl: a DIV=1 and a DIV=3 instance run side by side against a
// frame-level reference model (per-cycle expected bit computed from word, cycle index and DIV).
module tb_siso_arbiter_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         r0[2];
  logic         r1[2];
  logic [W-1:0] d0[2];
  logic [W-1:0] d1[2];
  bit           auto_drop;

  siso_arbiter_ctrl_if #(.WIDTH(W)) if_a ();
  siso_arbiter_ctrl_if #(.WIDTH(W)) if_b ();

  assign if_a.req0  = r0[0];
  assign if_a.data0 = d0[0];
  assign if_a.req1  = r1[0];
  assign if_a.data1 = d1[0];
  assign if_b.req0  = r0[1];
  assign if_b.data0 = d0[1];
  assign if_b.req1  = r1[1];
  assign if_b.data1 = d1[1];

  logic [1:0] go_w, se_w, fr_w, bz_w, ow_w, g0_w, g1_w;
  assign g0_w = {if_b.gnt0, if_a.gnt0};
  assign g1_w = {if_b.gnt1, if_a.gnt1};

  siso_arbiter_ctrl #(.WIDTH(W), .DIV(1)) u_div1 (
    .clk_i(clk), .rst_ni(rst_n), .req_if(if_a),
    .go_o(go_w[0]), .shift_en_o(se_w[0]), .frame_o(fr_w[0]), .busy_o(bz_w[0]), .owner_o(ow_w[0])
  );
  siso_arbiter_ctrl #(.WIDTH(W), .DIV(3)) u_div3 (
    .clk_i(clk), .rst_ni(rst_n), .req_if(if_b),
    .go_o(go_w[1]), .shift_en_o(se_w[1]), .frame_o(fr_w[1]), .busy_o(bz_w[1]), .owner_o(ow_w[1])
  );

  // Reference model: cycles remaining in the current frame and index within it.
  int           m_left[2];
  int           m_k[2];
  logic [W-1:0] m_word[2];
  logic         m_owner[2];
  logic         m_last[2];
  logic         gq[2][$];

  int n_checks = 0;
  int n_errors = 0;

  function automatic int divof(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(string tag, int i, logic obs, logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s[div%0d] observed=%b expected=%b t=%0t", tag, divof(i), obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_left[i]  = 0;
      m_k[i]     = 0;
      m_word[i]  = '0;
      m_owner[i] = 1'b0;
      m_last[i]  = 1'b1;
    end
  endtask

  task automatic model_step(int i);
    logic s;
    if (m_left[i] == 0) begin
      if (r0[i] || r1[i]) begin
        s          = (r0[i] && r1[i]) ? ~m_last[i] : r1[i];
        m_word[i]  = s ? d1[i] : d0[i];
        m_owner[i] = s;
        m_last[i]  = s;
        m_left[i]  = (W + 2) * divof(i);
        m_k[i]     = 0;
      end
    end else begin
      m_k[i]++;
      m_left[i]--;
    end
  endtask

  task automatic check_all();
    int   p;
    int   d;
    logic e_go, e_fr, e_se, e_bz, e_g0, e_g1;
    for (int i = 0; i < 2; i++) begin
      d = divof(i);
      e_go = 1'b0; e_fr = 1'b0; e_se = 1'b0; e_bz = 1'b0; e_g0 = 1'b0; e_g1 = 1'b0;
      if (m_left[i] > 0) begin
        p    = m_k[i] / d;
        e_bz = 1'b1;
        e_fr = (p <= W);
        e_se = ((m_k[i] % d) == d - 1);
        if (p == 0)       e_go = 1'b1;
        else if (p <= W)  e_go = m_word[i][W-p];
        e_g0 = (m_k[i] == 0) && !m_owner[i];
        e_g1 = (m_k[i] == 0) && m_owner[i];
      end
      chk("go", i, go_w[i], e_go);
      chk("frame", i, fr_w[i], e_fr);
      chk("shift_en", i, se_w[i], e_se);
      chk("busy", i, bz_w[i], e_bz);
      chk("owner", i, ow_w[i], m_owner[i]);
      chk("gnt0", i, g0_w[i], e_g0);
      chk("gnt1", i, g1_w[i], e_g1);
      if (g0_w[i]) gq[i].push_back(1'b0);
      if (g1_w[i]) gq[i].push_back(1'b1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
    check_all();
    if (auto_drop)
      for (int i = 0; i < 2; i++)
        if (m_left[i] > 0 && m_k[i] == 0) begin
          if (!m_owner[i]) r0[i] = 1'b0;
          else             r1[i] = 1'b0;
        end
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((m_left[0] != 0 || m_left[1] != 0 || r0[0] || r0[1] || r1[0] || r1[1]) && n < budget) begin
      tick();
      n++;
    end
    tick();
    n_checks++;
    assert (n < budget) else begin
      n_errors++;
      $error("FAIL wait_idle observed=%0d cycles expected=<%0d", n, budget);
    end
  endtask

  task automatic clear_gq();
    for (int i = 0; i < 2; i++) gq[i].delete();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      r0[i] = 1'b0; r1[i] = 1'b0; d0[i] = '0; d1[i] = '0;
    end
    auto_drop = 1'b1;
    model_reset();

    // Reset held, then idle with no requests.
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();

    // Single requester 0, word A5.
    for (int i = 0; i < 2; i++) begin d0[i] = 8'hA5; r0[i] = 1'b1; end
    wait_idle(100);

    // Both held continuously: grants alternate starting with requester 0.
    pulse_reset();
    auto_drop = 1'b0;
    clear_gq();
    for (int i = 0; i < 2; i++) begin
      d0[i] = 8'h0F; d1[i] = 8'hF0; r0[i] = 1'b1; r1[i] = 1'b1;
    end
    n = 0;
    while (gq[1].size() < 4 && n < 200) begin tick(); n++; end
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++)
        chk("alt_grant", i, (gq[i].size() > k) ? gq[i][k] : 1'bx, logic'(k % 2));
    for (int i = 0; i < 2; i++) begin r0[i] = 1'b0; r1[i] = 1'b0; end
    auto_drop = 1'b1;
    wait_idle(100);

    // Single requester 1, word 81.
    for (int i = 0; i < 2; i++) begin d1[i] = 8'h81; r1[i] = 1'b1; end
    wait_idle(100);

    // Reset in the middle of data bit 4 of the DIV=3 frame.
    for (int i = 0; i < 2; i++) begin
      d0[i] = W'($urandom); d1[i] = W'($urandom); r0[i] = 1'b1; r1[i] = 1'b1;
    end
    n = 0;
    while (!(m_left[1] > 0 && m_k[1] == 13) && n < 100) begin tick(); n++; end
    chk("mid_frame_reached", 1, (m_left[1] > 0 && m_k[1] == 13), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("async_go", i, go_w[i], 1'b0);
      chk("async_frame", i, fr_w[i], 1'b0);
      chk("async_busy", i, bz_w[i], 1'b0);
      chk("async_shift_en", i, se_w[i], 1'b0);
    end
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    clear_gq();
    for (int i = 0; i < 2; i++) begin r0[i] = 1'b1; r1[i] = 1'b1; end
    tick();
    for (int i = 0; i < 2; i++)
      chk("first_after_reset", i, (gq[i].size() > 0) ? gq[i][0] : 1'bx, 1'b0);
    wait_idle(200);

    // Requester 1 raised and dropped during a requester-0 frame: never granted.
    clear_gq();
    for (int i = 0; i < 2; i++) begin d0[i] = W'($urandom); r0[i] = 1'b1; end
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin d1[i] = W'($urandom); r1[i] = 1'b1; end
    repeat (2) tick();
    for (int i = 0; i < 2; i++) r1[i] = 1'b0;
    wait_idle(100);
    for (int i = 0; i < 2; i++) begin
      chk("dropped_req_grants", i, (gq[i].size() == 1), 1'b1);
      chk("dropped_req_owner", i, (gq[i].size() > 0) ? gq[i][0] : 1'bx, 1'b0);
    end

    // Random traffic, including requests withdrawn before their grant.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!r0[i] && $urandom_range(0, 5) == 0) begin r0[i] = 1'b1; d0[i] = W'($urandom); end
        if (!r1[i] && $urandom_range(0, 5) == 0) begin r1[i] = 1'b1; d1[i] = W'($urandom); end
        if (r0[i] && m_left[i] > 0 && $urandom_range(0, 40) == 0) r0[i] = 1'b0;
        if (r1[i] && m_left[i] > 0 && $urandom_range(0, 40) == 0) r1[i] = 1'b0;
      end
      tick();
    end
    wait_idle(200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
